// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART command receiver. It deserializes the RX line into bytes
// and joins each pair of consecutive bytes into one 16-bit command. The first
// byte becomes the high byte and the second becomes the low byte. Consumers
// see the result through a level cmd_rdy / clr_cmd_rdy handshake.
//
// Parameters:
//   BAUD_DIV     clocks per bit (legal range 8..4095)
//   GAP_TIMEOUT  max idle clocks allowed between the high byte and the low byte
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   RX           serial input; idles high; asynchronous to clk
//   clr_cmd_rdy  consumer acknowledge; clears cmd_rdy
//   cmd          assembled command {high byte, low byte}
//   cmd_rdy      cmd holds a valid, unconsumed command
//   frm_err      one-clock pulse when a stop bit samples 0
//   rx_busy      high from start detect through the stop-bit sample
module uart_cmd_rx #(
  parameter logic [11:0] BAUD_DIV    = 12'd2604,
  parameter logic [19:0] GAP_TIMEOUT = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err,
  output logic        rx_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_e;
  typedef enum logic {WAIT_HI, WAIT_LO} pair_state_e;

  logic        rx_meta_q, rx_s_q;
  byte_state_e byte_state_q, byte_state_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        busy_q, busy_d;
  logic        byte_done_q, byte_done_d;
  logic        frm_err_q, frm_err_d;
  pair_state_e pair_state_q, pair_state_d;
  logic [19:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  logic baud_zero, start_det, set_rdy, clr_rdy;

  assign baud_zero = (baud_cnt_q == '0);
  assign start_det = (byte_state_q == IDLE) && !rx_s_q;

  // Byte deserializer
  always_comb begin
    byte_state_d = byte_state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    busy_d       = busy_q;
    byte_done_d  = 1'b0;
    frm_err_d    = 1'b0;
    case (byte_state_q)
      IDLE: begin
        if (!rx_s_q) begin
          byte_state_d = START;
          baud_cnt_d   = BAUD_DIV >> 1;
          busy_d       = 1'b1;
        end
      end
      START: begin
        if (!baud_zero) begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end else if (rx_s_q) begin
          // The line went back high by mid-bit, so treat the low pulse as a glitch.
          byte_state_d = IDLE;
          busy_d       = 1'b0;
        end else begin
          byte_state_d = DATA;
          baud_cnt_d   = BAUD_DIV - 12'd1;
          bit_cnt_d    = '0;
        end
      end
      DATA: begin
        if (!baud_zero) begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end else begin
          shift_d    = {rx_s_q, shift_q[7:1]};
          baud_cnt_d = BAUD_DIV - 12'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (!baud_zero) begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end else begin
          byte_state_d = IDLE;
          busy_d       = 1'b0;
          byte_done_d  = rx_s_q;
          frm_err_d    = !rx_s_q;
        end
      end
      default: byte_state_d = IDLE;
    endcase
  end

  // Byte pairing. byte_done_q lags the stop-bit sample by one clock, so
  // cmd_rdy rises exactly one clock after that sample.
  always_comb begin
    pair_state_d = pair_state_q;
    gap_cnt_d    = gap_cnt_q;
    cmd_d        = cmd_q;
    set_rdy      = 1'b0;
    clr_rdy      = clr_cmd_rdy;
    case (pair_state_q)
      WAIT_HI: begin
        if (start_det) clr_rdy = 1'b1;
        if (byte_done_q) begin
          cmd_d[15:8]  = shift_q;
          pair_state_d = WAIT_LO;
          gap_cnt_d    = '0;
        end
      end
      WAIT_LO: begin
        if (frm_err_q) begin
          pair_state_d = WAIT_HI;
        end else if (byte_done_q) begin
          cmd_d[7:0]   = shift_q;
          set_rdy      = 1'b1;
          pair_state_d = WAIT_HI;
        end else if (byte_state_q == IDLE && !start_det) begin
          if (gap_cnt_q >= GAP_TIMEOUT) begin
            pair_state_d = WAIT_HI;
          end else begin
            gap_cnt_d = gap_cnt_q + 20'd1;
          end
        end
      end
      default: pair_state_d = WAIT_HI;
    endcase
    cmd_rdy_d = cmd_rdy_q;
    if (clr_rdy) cmd_rdy_d = 1'b0;
    if (set_rdy) cmd_rdy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      byte_state_q <= IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      byte_done_q  <= 1'b0;
      frm_err_q    <= 1'b0;
      pair_state_q <= WAIT_HI;
      gap_cnt_q    <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
    end else begin
      rx_meta_q    <= RX;
      rx_s_q       <= rx_meta_q;
      byte_state_q <= byte_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
      byte_done_q  <= byte_done_d;
      frm_err_q    <= frm_err_d;
      pair_state_q <= pair_state_d;
      gap_cnt_q    <= gap_cnt_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;
  assign rx_busy = busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed bench for uart_cmd_rx.
// It runs with BAUD_DIV=16 and GAP_TIMEOUT=200.
module tb_uart_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy, frm_err, rx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int frm_cnt  = 0;
  int frm_base;

  uart_cmd_rx #(.BAUD_DIV(12'd16), .GAP_TIMEOUT(20'd200)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .frm_err(frm_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bits(input logic [7:0] d);
    RX = 1'b0;
    tick(16);
    for (int unsigned i = 0; i < 8; i++) begin
      RX = d[i];
      tick(16);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bits(d);
    RX = stop;
    tick(16);
    RX = 1'b1;
  endtask

  // Sends the low byte and checks that cmd_rdy rises exactly one clock after
  // rx_busy falls at the stop-bit sample.
  task automatic send_lo_check(input logic [7:0] d, input logic [15:0] exp,
                               input logic clr_at_set, input string tag);
    logic found;
    drive_bits(d);
    RX = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!rx_busy) found = 1'b1;
    end
    check({tag, "_stop_seen"}, {31'd0, found}, 32'd1);
    check({tag, "_rdy_at_stop"}, {31'd0, cmd_rdy}, 32'd0);
    clr_cmd_rdy = clr_at_set;
    tick();
    clr_cmd_rdy = 1'b0;
    check({tag, "_rdy"}, {31'd0, cmd_rdy}, 32'd1);
    check({tag, "_cmd"}, {16'd0, cmd}, {16'd0, exp});
    tick(12);
  endtask

  task automatic ack(input string tag);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    check({tag, "_clr"}, {31'd0, cmd_rdy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_frm", {31'd0, frm_err}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    tick(20);

    // Basic pair, then acknowledge.
    send_byte(8'h47, 1'b1);
    send_lo_check(8'hF1, 16'h47F1, 1'b0, "pair1");
    ack("pair1");
    check("pair1_hold", {16'd0, cmd}, 32'h47F1);

    // Framing error on the high byte, then recovery.
    frm_base = frm_cnt;
    send_byte(8'h47, 1'b0);
    tick(20);
    check("frm_count", frm_cnt - frm_base, 32'd1);
    check("frm_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h20, 1'b1);
    send_lo_check(8'h00, 16'h2000, 1'b0, "pair2");
    ack("pair2");

    // Short glitch is not a start bit.
    frm_base = frm_cnt;
    RX = 1'b0;
    tick(5);
    RX = 1'b1;
    check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    tick(30);
    check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
    check("glitch_frm", frm_cnt - frm_base, 32'd0);
    check("glitch_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("glitch_cmd", {16'd0, cmd}, 32'h2000);

    // Gap timeout discards the high byte.
    send_byte(8'h47, 1'b1);
    tick(300);
    send_byte(8'h2F, 1'b1);
    check("gap_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_lo_check(8'hF0, 16'h2FF0, 1'b0, "gap");
    ack("gap");

    // Acknowledge in the same cycle as set: set wins.
    send_byte(8'h5A, 1'b1);
    send_lo_check(8'hC3, 16'h5AC3, 1'b1, "setwins");
    ack("setwins");

    // Break: two full low frames produce two framing errors and no command.
    frm_base = frm_cnt;
    RX = 1'b0;
    tick(400);
    RX = 1'b1;
    tick(400);
    check("break_frm", frm_cnt - frm_base, 32'd2);
    check("break_rdy", {31'd0, cmd_rdy}, 32'd0);

    // Reset during data bit 4 of the low byte.
    send_byte(8'h47, 1'b1);
    RX = 1'b0;
    tick(16);
    for (int unsigned i = 0; i < 4; i++) begin
      RX = 8'hF1 >> i;
      tick(16);
    end
    RX = 1'b1;
    tick(8);
    check("mid_busy", {31'd0, rx_busy}, 32'd1);
    check("mid_cmd_hi", {24'd0, cmd[15:8]}, 32'h47);
    rst_n = 1'b0;
    #1;
    check("arst_cmd", {16'd0, cmd}, 32'd0);
    check("arst_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("arst_busy", {31'd0, rx_busy}, 32'd0);
    check("arst_frm", {31'd0, frm_err}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    send_byte(8'h10, 1'b1);
    send_lo_check(8'h01, 16'h1001, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Inbound command front end of the Knight. Deserializes the UART RX line from the remote controller into bytes and pairs consecutive bytes into one 16-bit command: first byte is the high byte, second is the low byte.
- Presents the command to the command processor with a level cmd_rdy / clr_cmd_rdy handshake.
- Discards partial commands on framing errors and on excessive inter-byte gaps.

Parameters:
- BAUD_DIV, 2604, clocks per bit (19200 baud at 50 MHz); 12-bit; legal range 8..4095.
- GAP_TIMEOUT, 20'hFFFFF, max clocks from the high byte's stop-bit sample to the low byte's start-bit detect; 20-bit.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- RX  input  1  serial line from remote; idles high; asynchronous to clk
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
- cmd  output  16  assembled command, {high byte, low byte}
- cmd_rdy  output  1  level; cmd holds a valid, unconsumed command
- frm_err  output  1  one-clock pulse when a byte's stop bit samples 0
- rx_busy  output  1  high while a byte is being received (start detect through stop sample)

Behaviour:
- Reset: cmd=0, cmd_rdy=0, frm_err=0, rx_busy=0, byte FSM=IDLE, pairing state=WAIT_HI. Both synchronizer flops preset to 1, so no false start bit out of reset. Reset mid-byte or mid-pair abandons all partial data.
- Sync: RX passes through a two-flop synchronizer. All logic uses the synchronized rx_s. The 2-clock latency is accepted.
- Byte FSM, IDLE: on rx_s==0, go to START, load baud_cnt=BAUD_DIV>>1, assert rx_busy.
- Byte FSM, START: baud_cnt decrements each clock. At 0, sample rx_s.
  - If 1: false start (glitch); return to IDLE, drop rx_busy, no error.
  - If 0: go to DATA, reload baud_cnt=BAUD_DIV-1.
- Byte FSM, DATA: 8 samples at baud_cnt==0, each followed by reload to BAUD_DIV-1. Shift in LSB first. After the 8th sample, go to STOP.
- Byte FSM, STOP: at baud_cnt==0, sample the stop bit, then return to IDLE and drop rx_busy in that same cycle.
  - Stop=1: byte_done pulse.
  - Stop=0: frm_err pulse; the byte is dropped and pairing returns to WAIT_HI.
- Pairing, WAIT_HI: byte_done latches the byte into cmd[15:8], moves to WAIT_LO, and clears gap_cnt.
- Pairing, WAIT_LO:
  - gap_cnt increments each clock while the byte FSM is IDLE.
  - If gap_cnt reaches GAP_TIMEOUT before a start is detected, return to WAIT_HI; the stored high byte is discarded and no error is flagged.
  - byte_done latches the byte into cmd[7:0], sets cmd_rdy on the next clock edge, and returns to WAIT_HI.
- cmd stability: cmd[15:8] is written only on a high-byte byte_done, and cmd[7:0] only on a low-byte byte_done. cmd must not change while cmd_rdy=1, except that a new high-byte completion overwrites cmd[15:8].
- cmd_rdy: cleared by clr_cmd_rdy, or on start detect of a new high byte (a new command overrides the unconsumed one). If a set and a clear occur in the same cycle, the set wins.
- Timing: cmd_rdy rises exactly 1 clock after the low byte's stop-bit sample edge, i.e. about 2+9.5*BAUD_DIV clocks after the RX falling edge of the low byte.
- Break: a continuous low line produces frm_err once per 10-bit frame and never sets cmd_rdy.

Test Plan:
- BAUD_DIV=16. Send bytes 0x47 then 0xF1 -> cmd=16'h47F1 and cmd_rdy=1 one clock after the stop sample. Assert clr_cmd_rdy -> cmd_rdy=0 the next cycle and cmd remains 16'h47F1.
- Send 0x47 with stop bit forced 0 -> single frm_err pulse, cmd_rdy stays 0. Then send 0x20, 0x00 -> cmd=16'h2000, cmd_rdy=1.
- Pull RX low for 5 clocks (less than BAUD_DIV/2) -> rx_busy returns to 0, no byte_done, no frm_err, no cmd_rdy.
- GAP_TIMEOUT=200. Send 0x47, idle 300 clocks, then send 0x2F, 0xF0 -> cmd=16'h2FF0; the 0x47 is discarded.
- Assert clr_cmd_rdy in the same cycle the low byte of 0x5A,0xC3 completes -> cmd_rdy=1 (set wins), cmd=16'h5AC3.
- Assert rst_n=0 during data bit 4 of the low byte of 0x47,0xF1 -> outputs 0 immediately. After release, the next clean pair 0x10,0x01 yields cmd=16'h1001.
